// File: rtl/code_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : code_conv_pkg
// Purpose  : Shared widths, select encodings and code-range limits for the
//            code converter.
// Revision : 1.0 - initial release
// ============================================================================
package code_conv_pkg;

  localparam int CODE_W = 4;
  localparam int SEL_W  = 2;

  // Conversion mode encodings carried on select
  localparam logic [SEL_W-1:0] SEL_BIN2GRAY = 2'b00;
  localparam logic [SEL_W-1:0] SEL_BCD2XS3  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_GRAY2BIN = 2'b10;
  localparam logic [SEL_W-1:0] SEL_XS32BCD  = 2'b11;

  // Excess-3 offset and the largest legal BCD / excess-3 code words
  localparam logic [CODE_W-1:0] XS3_OFFSET = 4'd3;
  localparam logic [CODE_W-1:0] BCD_MAX    = 4'd9;
  localparam logic [CODE_W-1:0] XS3_MAX    = 4'd12;

endpackage
`default_nettype wire

// File: rtl/code_converter_if.sv
`default_nettype none
// ============================================================================
// Module   : code_converter_if
// Purpose  : Request (valid/code/select) and response (valid/code/err)
//            signals of the code converter. master drives requests,
//            slave (the converter) drives responses.
// Revision : 1.0 - initial release
// ============================================================================
interface code_converter_if;
  import code_conv_pkg::*;

  logic              in_valid;
  logic [CODE_W-1:0] code_in;
  logic [SEL_W-1:0]  select;
  logic              out_valid;
  logic [CODE_W-1:0] code_out;
  logic              err;

  modport master (
    output in_valid, code_in, select,
    input  out_valid, code_out, err
  );

  modport slave (
    input  in_valid, code_in, select,
    output out_valid, code_out, err
  );

endinterface
`default_nettype wire

// File: rtl/code_conv_core.sv
`default_nettype none
// ============================================================================
// Module   : code_conv_core
// Purpose  : Purely combinational conversion of one 4-bit code word in the
//            mode chosen by select, with a flag for words that are illegal
//            in that mode (result forced to zero when flagged).
// Revision : 1.0 - initial release
// ============================================================================
module code_conv_core
  import code_conv_pkg::*;
(
  input  logic [CODE_W-1:0] code_in,
  input  logic [SEL_W-1:0]  select,
  output logic [CODE_W-1:0] result,
  output logic              invalid
);

  logic [CODE_W-1:0] bin_to_gray;
  logic [CODE_W-1:0] gray_to_bin;

  assign bin_to_gray = code_in ^ (code_in >> 1);

  // Gray decode: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    gray_to_bin = '0;
    for (int i = 0; i < CODE_W; i++) begin
      gray_to_bin[i] = ^(code_in >> i);
    end
  end

  // Mode mux with range checks; out-of-range words give zero and the flag
  always_comb begin
    result  = '0;
    invalid = 1'b0;
    case (select)
      SEL_BIN2GRAY: result = bin_to_gray;
      SEL_BCD2XS3: begin
        if (code_in > BCD_MAX) invalid = 1'b1;
        else                   result  = code_in + XS3_OFFSET;
      end
      SEL_GRAY2BIN: result = gray_to_bin;
      SEL_XS32BCD: begin
        if ((code_in < XS3_OFFSET) || (code_in > XS3_MAX)) invalid = 1'b1;
        else                                               result  = code_in - XS3_OFFSET;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/code_converter.sv
`default_nettype none
// ============================================================================
// Module   : code_converter
// Purpose  : Registers the code_conv_core result one cycle after each
//            accepted input. Reset asserts asynchronously and releases the
//            output registers only after a two-flop synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module code_converter
  import code_conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  code_converter_if.slave  bus
);

  logic [1:0]        rst_sync;
  logic              rst_sync_n;
  logic [CODE_W-1:0] conv_result;
  logic              conv_invalid;
  logic [CODE_W-1:0] code_reg;
  logic              err_reg;
  logic              valid_reg;

  assign rst_sync_n = rst_sync[1];

  // Reset synchroniser: clears at once, releases two clock edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  code_conv_core u_core (
    .code_in (bus.code_in),
    .select  (bus.select),
    .result  (conv_result),
    .invalid (conv_invalid)
  );

  // Output registers: capture on in_valid, otherwise hold; valid pulses once
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      code_reg  <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        code_reg <= conv_result;
        err_reg  <= conv_invalid;
      end
    end
  end

  assign bus.code_out  = code_reg;
  assign bus.err       = err_reg;
  assign bus.out_valid = valid_reg;

endmodule
`default_nettype wire

// File: tb/tb_code_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_converter
// Purpose  : Self-checking bench for code_converter: a behavioural reference
//            model compared every cycle, plus hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_converter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  code_converter_if bus ();

  code_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference conversion from the mode definitions; returns {err, code}
  function automatic logic [4:0] ref_conv(input logic [1:0] s, input logic [3:0] c);
    logic [3:0] b;
    logic [4:0] r;
    r = 5'b00000;
    case (s)
      2'b00: r = {1'b0, c ^ (c >> 1)};
      2'b01: r = (c <= 4'd9) ? {1'b0, c + 4'd3} : 5'b10000;
      2'b10: begin
        // Gray decode as the inverse of Gray encode: search the binary word
        for (int k = 0; k < 16; k++) begin
          b = 4'(k);
          if ((b ^ (b >> 1)) == c) r = {1'b0, b};
        end
      end
      default: r = (c >= 4'd3 && c <= 4'd12) ? {1'b0, c - 4'd3} : 5'b10000;
    endcase
    return r;
  endfunction

  // Expected output registers tracked by the model
  logic [3:0] exp_code;
  logic       exp_err;
  logic       exp_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_code  = 4'd0;
      exp_err   = 1'b0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = bus.in_valid;
      if (bus.in_valid) {exp_err, exp_code} = ref_conv(bus.select, bus.code_in);
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    checks++;
    if (bus.code_out !== exp_code || bus.err !== exp_err || bus.out_valid !== exp_valid) begin
      errors++;
      $display("FAIL model t=%0t: got code_out=%b err=%b out_valid=%b, want code_out=%b err=%b out_valid=%b",
               $time, bus.code_out, bus.err, bus.out_valid, exp_code, exp_err, exp_valid);
    end
  end

  task automatic check_lit(input string name, input logic [3:0] c, input logic e, input logic v);
    checks++;
    if (bus.code_out !== c || bus.err !== e || bus.out_valid !== v) begin
      errors++;
      $display("FAIL %s: got code_out=%b err=%b out_valid=%b, want code_out=%b err=%b out_valid=%b",
               name, bus.code_out, bus.err, bus.out_valid, c, e, v);
    end
  endtask

  task automatic pin_model(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: model gave %b, want %b", name, got, want);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [3:0] c);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.select   = s;
    bus.code_in  = c;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic one(input string name, input logic [1:0] s, input logic [3:0] c,
                     input logic [3:0] ec, input logic ee);
    drive(s, c);
    idle();
    @(negedge clk);
    check_lit(name, ec, ee, 1'b1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.select   = 2'b00;
    bus.code_in  = 4'd0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_lit("reset_state", 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    pin_model("model_b2g", ref_conv(2'b00, 4'b1011), 5'b01110);
    pin_model("model_g2b", ref_conv(2'b10, 4'b1110), 5'b01011);
    pin_model("model_xs3_bad", ref_conv(2'b01, 4'b1010), 5'b10000);
    pin_model("model_bcd", ref_conv(2'b11, 4'b1100), 5'b01001);
    pin_model("model_bcd_bad", ref_conv(2'b11, 4'b1101), 5'b10000);

    one("b2g_1011", 2'b00, 4'b1011, 4'b1110, 1'b0);
    @(negedge clk);
    check_lit("hold_after_idle", 4'b1110, 1'b0, 1'b0);
    one("xs3_0111", 2'b01, 4'b0111, 4'b1010, 1'b0);
    one("xs3_1010_bad", 2'b01, 4'b1010, 4'b0000, 1'b1);
    one("xs3_1001_edge", 2'b01, 4'b1001, 4'b1100, 1'b0);
    one("g2b_1110", 2'b10, 4'b1110, 4'b1011, 1'b0);
    one("bcd_1100", 2'b11, 4'b1100, 4'b1001, 1'b0);
    one("bcd_0010_bad", 2'b11, 4'b0010, 4'b0000, 1'b1);
    one("bcd_0011_edge", 2'b11, 4'b0011, 4'b0000, 1'b0);
    one("bcd_1101_bad", 2'b11, 4'b1101, 4'b0000, 1'b1);

    // Mode change on back-to-back inputs: second result uses the new mode
    drive(2'b00, 4'b0101);
    drive(2'b11, 4'b0101);
    idle();
    @(negedge clk);
    check_lit("sel_switch", 4'b0010, 1'b0, 1'b1);

    // Full sweeps 1111,0000..1110 per mode; out_valid must stay high
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 16; k++) begin
        drive(2'(s), 4'(15 + k));
        if (k > 0) begin
          @(negedge clk);
          checks++;
          if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sweep_valid sel=%0d k=%0d: out_valid=%b, want 1", s, k, bus.out_valid);
          end
        end
      end
      idle();
    end

    // Asynchronous reset dropped between edges during a sweep
    for (int k = 0; k < 16; k++) begin
      drive(2'b01, 4'(15 + k));
      if (k == 9) begin
        #2 rst_n = 1'b0;
        #1 check_lit("reset_mid_sweep", 4'd0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_lit("post_reset_idle", 4'd0, 1'b0, 1'b0);
    one("after_reset", 2'b01, 4'b0100, 4'b0111, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
